// File: rtl/fault_inject_ram_pkg.sv
// Shared fault-mode definitions for the fault-injecting RAM and its fault logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fault_inject_ram_pkg;

    typedef logic [1:0] fault_mode_t;

    localparam fault_mode_t FAULT_NONE = 2'b00;
    localparam fault_mode_t FAULT_SA0  = 2'b01;
    localparam fault_mode_t FAULT_SA1  = 2'b10;
    localparam fault_mode_t FAULT_TF   = 2'b11;

endpackage

// File: rtl/fault_inject_ram_fault_ctrl.sv
// Fault shaping: maps the requested write data and the stored bits to the values
// actually written and read, given the active fault mode.
// Latency: purely combinational. Backpressure: none (always accepts).
//
// Ports:
//   mode      active fault mode
//   wr_match  write address hits the faulty cell
//   rd_match  read address hits the faulty cell
//   wr_stored current content of the cell being written
//   wr_data   requested write data
//   rd_stored current content of the cell being read
//   wr_eff    value to store
//   rd_eff    value to return on a read
module fault_inject_ram_fault_ctrl
    import fault_inject_ram_pkg::*;
(
    input  fault_mode_t mode,
    input  logic        wr_match,
    input  logic        rd_match,
    input  logic        wr_stored,
    input  logic        wr_data,
    input  logic        rd_stored,
    output logic        wr_eff,
    output logic        rd_eff
);

    always_comb begin
        wr_eff = wr_data;
        if (wr_match) begin
            case (mode)
                FAULT_SA0: wr_eff = 1'b0;
                FAULT_SA1: wr_eff = 1'b1;
                // A 0->1 transition is lost; 0 writes and 1-over-1 go through.
                FAULT_TF:  wr_eff = wr_data & wr_stored;
                default:   wr_eff = wr_data;
            endcase
        end
    end

    always_comb begin
        rd_eff = rd_stored;
        if (rd_match) begin
            case (mode)
                FAULT_SA0: rd_eff = 1'b0;
                FAULT_SA1: rd_eff = 1'b1;
                default:   rd_eff = rd_stored;
            endcase
        end
    end

endmodule

// File: rtl/fault_inject_ram.sv
// 1-bit x 2**AWIDTH synchronous RAM with fault injection on cell FAULT_ADDR,
// used as the memory under test for MBIST. Latency: 1 cycle read (registered).
// Backpressure: none; a read and a write are accepted every cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all cells)
//   we/wr_addr/data_in write port
//   re/rd_addr        read port; data_out updates only when re=1
//   data_out          registered read data
//   fault             fault mode: none / stuck-at-0 / stuck-at-1 / transition-up
module fault_inject_ram
    import fault_inject_ram_pkg::*;
#(
    parameter int AWIDTH     = 4,
    parameter int FAULT_ADDR = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic              data_in,
    input  logic              re,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              data_out,
    input  logic [1:0]        fault
);

    localparam int                DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] FADDR = AWIDTH'(FAULT_ADDR);

    logic [DEPTH-1:0] mem;
    logic             wr_eff;
    logic             rd_eff;

    fault_inject_ram_fault_ctrl u_fault_ctrl (
        .mode      (fault_mode_t'(fault)),
        .wr_match  (wr_addr == FADDR),
        .rd_match  (rd_addr == FADDR),
        .wr_stored (mem[wr_addr]),
        .wr_data   (data_in),
        .rd_stored (mem[rd_addr]),
        .wr_eff    (wr_eff),
        .rd_eff    (rd_eff)
    );

    // Read samples the pre-edge array, so a same-address read/write returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem      <= '0;
            data_out <= 1'b0;
        end else begin
            if (re) begin
                data_out <= rd_eff;
            end
            if (we) begin
                mem[wr_addr] <= wr_eff;
            end
        end
    end

endmodule

// File: tb/tb_fault_inject_ram.sv
module tb_fault_inject_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [3:0] wr_addr;
    logic       data_in;
    logic       re;
    logic [3:0] rd_addr;
    logic       data_out;
    logic [1:0] fault;

    int errors = 0;
    int checks = 0;

    fault_inject_ram #(.AWIDTH(4), .FAULT_ADDR(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wr_addr  (wr_addr),
        .data_in  (data_in),
        .re       (re),
        .rd_addr  (rd_addr),
        .data_out (data_out),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Every task applies inputs just after a rising edge and returns #1 after the next one.
    task automatic tick;
        @(posedge clk);
        #1;
        rst = 1'b0;
        we  = 1'b0;
        re  = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [3:0] a, input logic d);
        we = 1'b1; wr_addr = a; data_in = d;
        tick();
    endtask

    task automatic do_read(input logic [3:0] a, input logic exp, input string tag);
        re = 1'b1; rd_addr = a;
        tick();
        check($sformatf("%s[%0d]", tag, a), data_out, exp);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0;
        wr_addr = '0; rd_addr = '0; data_in = 1'b0; fault = 2'b00;
        tick();
        check("reset_dout", data_out, 1'b0);

        // Ideal memory after reset reads all zero.
        for (int i = 0; i < 16; i++) do_read(4'(i), 1'b0, "rst_all");

        // Basic write/read, neighbour untouched, hold with re=0.
        do_write(4'd3, 1'b1);
        do_read(4'd3, 1'b1, "ideal");
        tick();
        check("hold_re0", data_out, 1'b1);
        do_read(4'd4, 1'b0, "ideal");

        // Stuck-at-0 on cell 5.
        do_reset();
        fault = 2'b01;
        for (int i = 0; i < 16; i++) do_write(4'(i), 1'b1);
        for (int i = 0; i < 16; i++) do_read(4'(i), (i == 5) ? 1'b0 : 1'b1, "sa0");
        fault = 2'b00;
        do_read(4'd5, 1'b0, "sa0_cleared");

        // Stuck-at-1 on cell 5.
        do_reset();
        fault = 2'b10;
        for (int i = 0; i < 16; i++) do_write(4'(i), 1'b0);
        for (int i = 0; i < 16; i++) do_read(4'(i), (i == 5) ? 1'b1 : 1'b0, "sa1");
        fault = 2'b00;
        do_read(4'd5, 1'b1, "sa1_cleared");

        // Transition-up fault on cell 5.
        do_reset();
        fault = 2'b11;
        do_write(4'd5, 1'b0);
        do_write(4'd5, 1'b1);
        do_read(4'd5, 1'b0, "tf_up_lost");
        do_write(4'd6, 1'b1);
        do_read(4'd6, 1'b1, "tf_other");
        fault = 2'b00;
        do_write(4'd5, 1'b1);
        fault = 2'b11;
        do_write(4'd5, 1'b1);
        do_read(4'd5, 1'b1, "tf_1over1");
        do_write(4'd5, 1'b0);
        do_read(4'd5, 1'b0, "tf_write0");

        // Same-cycle read and write to one address: old data returned.
        we = 1'b1; wr_addr = 4'd2; data_in = 1'b1;
        re = 1'b1; rd_addr = 4'd2;
        tick();
        check("rbw_old", data_out, 1'b0);
        do_read(4'd2, 1'b1, "rbw_new");

        // Reset mid-sequence, overriding a simultaneous write and read.
        fault = 2'b00;
        do_write(4'd7, 1'b1);
        do_read(4'd7, 1'b1, "pre_rst");
        rst = 1'b1;
        we = 1'b1; wr_addr = 4'd8; data_in = 1'b1;
        re = 1'b1; rd_addr = 4'd7;
        tick();
        check("rst_dout", data_out, 1'b0);
        do_read(4'd7, 1'b0, "post_rst");
        do_read(4'd8, 1'b0, "rst_over_we");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
